// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Debounces N active-low pushbutton inputs. Each raw pin first goes through a
// two-flop synchronizer. A per-channel counter then counts consecutive cycles
// in which the synchronized level differs from the accepted level. After
// DEBOUNCE_CYCLES such cycles in a row, the new level is accepted. Any return
// to the accepted level clears the counter, so short glitches are dropped.
//
// From the first edge that samples a new stable raw level, button_n changes
// DEBOUNCE_CYCLES+2 rising edges later. That is 2 synchronizer edges plus
// DEBOUNCE_CYCLES counting edges.
//
// Parameters:
//   N                number of independent channels (default 2)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change, 2..65535
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset (glitch-free; deasserted
//                  synchronously upstream)
//   button_raw_n   [N] raw pins, active-low (0 = pressed)
//   button_n       [N] debounced level, active-low
//   press          [N] one-cycle registered pulse when button_n goes 1->0
//   release_pulse  [N] one-cycle registered pulse when button_n goes 0->1
//
// Build option:
//   BUTTON_DEBOUNCE_RELEASE_PULSE_EN  when defined, release_pulse is generated.
//                                     Otherwise it is tied to 0 and has no
//                                     registers.
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int N               = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] button_raw_n,
  output logic [N-1:0] button_n,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [N-1:0]  sync1_q, sync1_d;
  logic [N-1:0]  sync2_q, sync2_d;
  logic [N-1:0]  btn_q,   btn_d;
  logic [N-1:0]  press_q, press_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  load;

  always_comb begin
    sync1_d = button_raw_n;
    sync2_d = sync1_q;
    btn_d   = btn_q;
    press_d = '0;
    load    = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != btn_q[i]) begin
        // The counter saturates at CNT_MAX. On that edge the new level is
        // accepted and the counter restarts, so it can never wrap.
        if (cnt_q[i] == CNT_MAX) begin
          load[i]  = 1'b1;
          btn_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      // A load while the accepted level is 1 is a 1->0 transition, i.e. a press.
      press_d[i] = load[i] & btn_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      btn_q   <= '1;
      press_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign button_n = btn_q;
  assign press    = press_q;

`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
  logic [N-1:0] release_q, release_d;

  always_comb begin
    release_d = load & ~btn_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      release_q <= '0;
    end else begin
      release_q <= release_d;
    end
  end

  assign release_pulse = release_q;
`else
  assign release_pulse = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Testbench for button_debounce with N=2 and DEBOUNCE_CYCLES=4.
//
// Reference model: the synchronized level seen at edge k is the raw level
// sampled two edges earlier. The accepted level flips when the last
// DEBOUNCE_CYCLES synchronized samples all differ from it.
//
// Build option: BUTTON_DEBOUNCE_RELEASE_PULSE_EN selects whether release
// pulses are expected.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int NCH = 2;
  localparam int DC  = 4;
`ifdef BUTTON_DEBOUNCE_RELEASE_PULSE_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] button_raw_n;
  logic [NCH-1:0] button_n;
  logic [NCH-1:0] press;
  logic [NCH-1:0] release_pulse;

  button_debounce #(.N(NCH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_raw_n (button_raw_n),
    .button_n     (button_n),
    .press        (press),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  bit             pipe_q [NCH][$];
  bit             win_q  [NCH][$];
  logic [NCH-1:0] m_btn, m_press, m_rel;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      pipe_q[c].delete();
      win_q[c].delete();
      pipe_q[c].push_back(1'b1);
      pipe_q[c].push_back(1'b1);
      for (int j = 0; j < DC; j++) win_q[c].push_back(1'b1);
    end
    m_btn   = '1;
    m_press = '0;
    m_rel   = '0;
  endtask

  task automatic model_step(input logic [NCH-1:0] raw);
    bit s;
    bit flip;
    for (int c = 0; c < NCH; c++) begin
      pipe_q[c].push_back(raw[c]);
      s = pipe_q[c].pop_front();
      win_q[c].push_back(s);
      void'(win_q[c].pop_front());
      flip = 1'b1;
      for (int j = 0; j < win_q[c].size(); j++)
        if (win_q[c][j] == m_btn[c]) flip = 1'b0;
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (flip) begin
        if (m_btn[c]) m_press[c] = 1'b1;
        else          m_rel[c]   = 1'b1;
        m_btn[c] = ~m_btn[c];
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One rising edge: advance the model, then compare the DUT #1 after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(button_raw_n);
    #1;
    chk("model button_n", 32'(button_n), 32'(m_btn));
    chk("model press", 32'(press), 32'(m_press));
    chk("model release", 32'(release_pulse), 32'(m_rel & {NCH{REL_EN}}));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [NCH-1:0] raw;
    logic [NCH-1:0] btn;
    logic [NCH-1:0] prs;
    logic [NCH-1:0] rel;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int first;
    int cnt;
    logic [NCH-1:0] seen;
    int hold [NCH];
    logic [NCH-1:0] lvl;

    // Channel-0 press for 5 cycles, then release (one record per edge).
    for (int i = 0; i < 5; i++) tbl[i] = '{2'b10, 2'b11, 2'b00, 2'b00};
    tbl[5] = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 6; i < 10; i++) tbl[i] = '{2'b11, 2'b10, 2'b00, 2'b00};
    tbl[10] = '{2'b11, 2'b11, 2'b00, 2'b01};
    tbl[11] = '{2'b11, 2'b11, 2'b00, 2'b00};

    // Reset state, checked while rst_n is low.
    rst_n        = 1'b0;
    button_raw_n = 2'b11;
    #13;
    chk("reset button_n", 32'(button_n), 32'h3);
    chk("reset press", 32'(press), 32'h0);
    chk("reset release", 32'(release_pulse), 32'h0);
    #10;
    rst_n = 1'b1;
    model_reset();

    // Idle for 200 time units.
    ticks(20);
    chk("idle button_n", 32'(button_n), 32'h3);

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      button_raw_n = tbl[i].raw;
      tick();
      chk($sformatf("tbl[%0d] button_n", i), 32'(button_n), 32'(tbl[i].btn));
      chk($sformatf("tbl[%0d] press", i), 32'(press), 32'(tbl[i].prs));
      chk($sformatf("tbl[%0d] release", i), 32'(release_pulse), 32'(tbl[i].rel & {NCH{REL_EN}}));
    end
    ticks(4);

    // A 2-cycle glitch on channel 1 must be rejected.
    cnt = 0;
    button_raw_n = 2'b01;
    for (int i = 0; i < 2; i++) begin tick(); if (press[1]) cnt++; end
    button_raw_n = 2'b11;
    for (int i = 0; i < 12; i++) begin tick(); if (press[1]) cnt++; end
    chk("glitch press count", 32'(cnt), 32'd0);
    chk("glitch button_n", 32'(button_n), 32'h3);

    // Bounce every cycle for 8 cycles, then hold steady low.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      button_raw_n = (i % 2 == 0) ? 2'b10 : 2'b11;
      tick();
      if (press[0]) cnt++;
    end
    chk("bounce early press", 32'(cnt), 32'd0);
    button_raw_n = 2'b10;
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (press[0]) begin cnt++; if (first == 0) first = k; end
    end
    chk("bounce press edge", 32'(first), 32'd6);
    chk("bounce press count", 32'(cnt), 32'd1);
    button_raw_n = 2'b11;
    ticks(12);

    // Both channels pressed together, then released together.
    button_raw_n = 2'b00;
    first = 0; seen = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (press != 2'b00 && first == 0) begin first = k; seen = press; end
    end
    chk("dual press edge", 32'(first), 32'd6);
    chk("dual press value", 32'(seen), 32'h3);
    button_raw_n = 2'b11;
    first = 0; seen = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (button_n == 2'b11 && first == 0) begin first = k; seen = release_pulse; end
    end
    chk("dual release edge", 32'(first), 32'd6);
    chk("dual release value", 32'(seen), 32'({NCH{REL_EN}}));

    // Reset while a channel-0 press is at count 2; the press must restart.
    button_raw_n = 2'b10;
    ticks(4);
    rst_n = 1'b0;
    #1;
    chk("midreset button_n", 32'(button_n), 32'h3);
    chk("midreset press", 32'(press), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (press[0] && first == 0) first = k;
    end
    chk("post-reset press edge", 32'(first), 32'd6);
    button_raw_n = 2'b11;
    ticks(12);

    // Randomized hold lengths with occasional resets.
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    lvl = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          hold[c] = int'($urandom_range(1, 8));
          lvl[c]  = 1'($urandom_range(0, 1));
        end
        hold[c]--;
      end
      button_raw_n = lvl;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand reset button_n", 32'(button_n), 32'h3);
        model_reset();
        #2;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
